controle_ula: RTL and testbench



---
 rtl/controle_ula.sv | 205 ++++++++++++++++++++
 tb/tb_controle_ula.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_ula.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | controle_ula: sequences one ULA instruction per handshake over an 8x16 bank |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module controle_ula #(
    parameter int bits_palavra  = 16,
    parameter int bits_controle = 5,
    parameter int n_regs        = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [bits_controle-1:0]     instr_op,
    input  logic [$clog2(n_regs)-1:0]    instr_rd,
    input  logic [$clog2(n_regs)-1:0]    instr_ra,
    input  logic [$clog2(n_regs)-1:0]    instr_rb,
    output logic [bits_palavra-1:0]      operandoA,
    output logic [bits_palavra-1:0]      operandoB,
    output logic [bits_controle-1:0]     controle,
    input  logic [bits_palavra-1:0]      resultadoOp,
    input  logic                         Z,
    input  logic                         C,
    input  logic                         S,
    input  logic                         O,
    output logic [3:0]                   flags,
    output logic                         concluido,
    output logic                         erro,
    input  logic                         carga_en,
    input  logic [$clog2(n_regs)-1:0]    carga_sel,
    input  logic [bits_palavra-1:0]      carga_dado,
    input  logic [$clog2(n_regs)-1:0]    le_sel,
    output logic [bits_palavra-1:0]      le_dado
);

    localparam int IDX_W = $clog2(n_regs);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        LEITURA = 2'd1,
        EXECUTA = 2'd2,
        ESCRITA = 2'd3
    } estado_t;

    typedef enum logic [2:0] {
        CL_ARIT   = 3'd0,
        CL_DESL   = 3'd1,
        CL_LOG    = 3'd2,
        CL_CONST  = 3'd3,
        CL_ILEGAL = 3'd4
    } classe_t;

    function automatic classe_t classifica(input logic [bits_controle-1:0] op);
        classe_t cl;
        case (op)
            5'b00000, 5'b00001, 5'b00011,
            5'b00100, 5'b00101, 5'b00110: cl = CL_ARIT;
            5'b01000, 5'b01001:           cl = CL_DESL;
            5'b10001, 5'b10010:           cl = CL_LOG;
            5'b10000, 5'b10011, 5'b11111: cl = CL_CONST;
            default: cl = (op >= 5'b10100 && op <= 5'b11110) ? CL_LOG : CL_ILEGAL;
        endcase
        return cl;
    endfunction

    estado_t                   estado_q, estado_d;
    logic [bits_controle-1:0]  op_q, op_d;
    logic [IDX_W-1:0]          rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
    logic [bits_palavra-1:0]   opA_q, opA_d, opB_q, opB_d;
    logic [bits_controle-1:0]  ctrl_q, ctrl_d;
    logic [bits_palavra-1:0]   res_q, res_d;
    logic                      c_q, c_d, o_q, o_d;
    logic [3:0]                flags_q, flags_d;
    logic                      concl_q, concl_d, erro_q, erro_d;
    logic                      wr_en;
    logic [bits_palavra-1:0]   bank_q [n_regs];
    logic                      z_loc, s_loc;
    logic                      unused_ula_zs;

    // Z and S are recomputed from the captured result; the ULA's versions are not used.
    assign unused_ula_zs = Z ^ S;
    assign z_loc         = (res_q == '0);
    assign s_loc         = res_q[bits_palavra-1];

    always_comb begin
        estado_d = estado_q;
        op_d     = op_q;
        rd_d     = rd_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        ctrl_d   = ctrl_q;
        res_d    = res_q;
        c_d      = c_q;
        o_d      = o_q;
        flags_d  = flags_q;
        concl_d  = 1'b0;
        erro_d   = 1'b0;
        wr_en    = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (instr_valid) begin
                    op_d     = instr_op;
                    rd_d     = instr_rd;
                    ra_d     = instr_ra;
                    rb_d     = instr_rb;
                    estado_d = LEITURA;
                end
            end
            LEITURA: begin
                if (classifica(op_q) == CL_ILEGAL) begin
                    concl_d  = 1'b1;
                    erro_d   = 1'b1;
                    estado_d = OCIOSO;
                end else begin
                    opA_d    = bank_q[ra_q];
                    opB_d    = bank_q[rb_q];
                    ctrl_d   = op_q;
                    estado_d = EXECUTA;
                end
            end
            EXECUTA: begin
                res_d    = resultadoOp;
                c_d      = C;
                o_d      = O;
                estado_d = ESCRITA;
            end
            ESCRITA: begin
                wr_en    = 1'b1;
                concl_d  = 1'b1;
                estado_d = OCIOSO;
                case (classifica(op_q))
                    CL_ARIT: flags_d = {z_loc, c_q, s_loc, o_q};
                    CL_DESL: flags_d = {z_loc, c_q, s_loc, flags_q[0]};
                    CL_LOG:  flags_d = {z_loc, flags_q[2], s_loc, flags_q[0]};
                    default: flags_d = flags_q;
                endcase
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            op_q     <= '0;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
            ctrl_q   <= '0;
            res_q    <= '0;
            c_q      <= 1'b0;
            o_q      <= 1'b0;
            flags_q  <= '0;
            concl_q  <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            ctrl_q   <= ctrl_d;
            res_q    <= res_d;
            c_q      <= c_d;
            o_q      <= o_d;
            flags_q  <= flags_d;
            concl_q  <= concl_d;
            erro_q   <= erro_d;
        end
    end

    // Writeback is issued after the external load so it wins a same-index collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < n_regs; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            if (carga_en) begin
                bank_q[carga_sel] <= carga_dado;
            end
            if (wr_en) begin
                bank_q[rd_q] <= res_q;
            end
        end
    end

    assign instr_ready = (estado_q == OCIOSO) && rst_n;
    assign operandoA   = opA_q;
    assign operandoB   = opB_q;
    assign controle    = ctrl_q;
    assign flags       = flags_q;
    assign concluido   = concl_q;
    assign erro        = erro_q;
    assign le_dado     = bank_q[le_sel];

endmodule
`default_nettype wire

// File: tb/tb_controle_ula.sv
`default_nettype none
// Bench for controle_ula: a behavioural ULA drives the DUT, and a sequential
// register-bank/flag model predicts every writeback, flag set and handshake.
module tb_controle_ula;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, instr_ready;
    logic [4:0]  instr_op;
    logic [2:0]  instr_rd, instr_ra, instr_rb;
    logic [15:0] operandoA, operandoB, resultadoOp;
    logic [4:0]  controle;
    logic        Z, C, S, O;
    logic [3:0]  flags;
    logic        concluido, erro;
    logic        carga_en;
    logic [2:0]  carga_sel, le_sel;
    logic [15:0] carga_dado, le_dado;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] mbank [8];
    logic [3:0]  mflags;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    controle_ula dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
        .operandoA(operandoA), .operandoB(operandoB), .controle(controle),
        .resultadoOp(resultadoOp), .Z(Z), .C(C), .S(S), .O(O),
        .flags(flags), .concluido(concluido), .erro(erro),
        .carga_en(carga_en), .carga_sel(carga_sel), .carga_dado(carga_dado),
        .le_sel(le_sel), .le_dado(le_dado)
    );

    // Behavioural ULA: returns {C, O, result}
    function automatic logic [17:0] ula(input logic [15:0] a, input logic [15:0] b,
                                        input logic [4:0] op);
        logic [16:0] t;
        logic [15:0] r;
        logic        c, o;
        case (op)
            5'b00000: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[15:0]; c = t[16];
                o = (a[15] == b[15]) && (r[15] != a[15]);
            end
            5'b00101: begin
                r = a - b; c = (a < b);
                o = (a[15] != b[15]) && (r[15] != a[15]);
            end
            5'b01000: begin r = {a[14:0], 1'b0}; c = a[15]; o = 1'b1; end
            5'b01001: begin r = {a[15], a[15:1]}; c = a[0]; o = 1'b1; end
            5'b10001: begin r = a & b; c = 1'b1; o = 1'b1; end
            default:  begin r = a ^ (b + {11'd0, op}); c = r[0]; o = r[1]; end
        endcase
        return {c, o, r};
    endfunction

    logic [17:0] ula_out;
    assign ula_out     = ula(operandoA, operandoB, controle);
    assign resultadoOp = ula_out[15:0];
    assign C           = ula_out[17];
    assign O           = ula_out[16];
    // Deliberately wrong Z/S so any use of them shows up
    assign Z           = (ula_out[15:0] != 16'h0000);
    assign S           = ~ula_out[15];

    function automatic bit is_illegal(input logic [4:0] op);
        return !(op inside {[0:1], [3:6], 8, 9, [16:31]});
    endfunction

    function automatic logic [3:0] exp_flags(input logic [4:0] op, input logic [15:0] r,
                                             input logic c, input logic o, input logic [3:0] old);
        logic z, s;
        z = (r == 16'h0000);
        s = r[15];
        if (op inside {[0:1], [3:6]}) return {z, c, s, o};
        if (op inside {8, 9})         return {z, c, s, old[0]};
        if (op inside {17, 18, [20:30]}) return {z, old[2], s, old[0]};
        return old;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] idx, input logic [15:0] val);
        carga_en = 1'b1; carga_sel = idx; carga_dado = val;
        tick();
        carga_en = 1'b0;
        mbank[idx] = val;
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (!instr_ready && w < 20) begin
            tick();
            w++;
        end
        chk(tag, 32'(w < 20), 32'd1);
    endtask

    // ph: 0 none, 1 external load to ra at the read edge, 3 external load to rd at the writeback edge
    task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input int ph, input logic [15:0] cdat);
        logic [15:0] a, b, r;
        logic [17:0] u;
        logic [3:0]  f;
        bit          ileg;
        a = mbank[ra]; b = mbank[rb];
        u = ula(a, b, op); r = u[15:0];
        ileg = is_illegal(op);
        f = ileg ? mflags : exp_flags(op, r, u[17], u[16], mflags);
        instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
        instr_valid = 1'b1; le_sel = rd;
        wait_ready("accept_timeout");
        tick();
        instr_valid = 1'b0;
        chk("ready_low_after_accept", 32'(instr_ready), 32'd0);
        if (ph == 1) begin carga_en = 1'b1; carga_sel = ra; carga_dado = cdat; end
        tick();
        carga_en = 1'b0;
        if (ph == 1) mbank[ra] = cdat;
        if (ileg) begin
            chk("ilegal_erro", 32'(erro), 32'd1);
            chk("ilegal_concluido", 32'(concluido), 32'd1);
            chk("ilegal_ready", 32'(instr_ready), 32'd1);
            chk("ilegal_flags", 32'(flags), 32'(mflags));
            chk("ilegal_rd", 32'(le_dado), 32'(mbank[rd]));
            tick();
            chk("ilegal_erro_pulse", 32'(erro), 32'd0);
            return;
        end
        chk("operandoA", 32'(operandoA), 32'(a));
        chk("operandoB", 32'(operandoB), 32'(b));
        chk("controle", 32'(controle), 32'(op));
        chk("concluido_early1", 32'(concluido), 32'd0);
        tick();
        chk("concluido_early2", 32'(concluido), 32'd0);
        if (ph == 3) begin carga_en = 1'b1; carga_sel = rd; carga_dado = cdat; end
        tick();
        carga_en = 1'b0;
        mbank[rd] = r;
        mflags = f;
        chk("concluido", 32'(concluido), 32'd1);
        chk("erro_legal", 32'(erro), 32'd0);
        chk("ready_back", 32'(instr_ready), 32'd1);
        chk("flags", 32'(flags), 32'(f));
        chk("writeback", 32'(le_dado), 32'(r));
    endtask

    initial begin
        logic [4:0]  bop [3];
        logic [2:0]  brd [3], bra [3], brb [3];
        int          tacc [3];
        logic [17:0] u;
        logic [4:0]  rop;

        rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0;
        instr_rd = '0; instr_ra = '0; instr_rb = '0;
        carga_en = 1'b0; carga_sel = '0; carga_dado = '0; le_sel = '0;
        for (int i = 0; i < 8; i++) mbank[i] = 16'h0000;
        mflags = 4'h0;
        repeat (3) tick();
        chk("reset_ready_low", 32'(instr_ready), 32'd0);
        rst_n = 1'b1;
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_opA", 32'(operandoA), 32'd0);
        chk("reset_ctrl", 32'(controle), 32'd0);
        chk("reset_concluido", 32'(concluido), 32'd0);
        for (int i = 0; i < 8; i++) begin
            le_sel = 3'(i);
            #1;
            chk("reset_bank", 32'(le_dado), 32'd0);
        end

        // Add with overflow, then logic keeps C/O
        load(3'd1, 16'h7FFF); load(3'd2, 16'h0001);
        issue(5'b00000, 3'd3, 3'd1, 3'd2, 0, 16'h0);
        chk("add_ovf_flags_abs", 32'(flags), 32'h3);
        chk("add_ovf_result_abs", 32'(le_dado), 32'h8000);
        load(3'd4, 16'hF0F0); load(3'd5, 16'h0FF0);
        issue(5'b10001, 3'd6, 3'd4, 3'd5, 0, 16'h0);
        chk("logic_flags_abs", 32'(flags), 32'h1);

        // Subtract to zero, then arithmetic right shift keeps O
        load(3'd1, 16'h0005); load(3'd2, 16'h0005);
        issue(5'b00101, 3'd7, 3'd1, 3'd2, 0, 16'h0);
        chk("sub_zero_flags_abs", 32'(flags), 32'h8);
        load(3'd1, 16'h8003);
        issue(5'b01001, 3'd2, 3'd1, 3'd1, 0, 16'h0);
        chk("asr_result_abs", 32'(le_dado), 32'hC001);
        chk("asr_flags_abs", 32'(flags), 32'h6);

        // Illegal opcode, then collisions with the external load
        issue(5'b00010, 3'd2, 3'd1, 3'd4, 0, 16'h0);
        issue(5'b00000, 3'd5, 3'd4, 3'd1, 1, 16'hAAAA);
        issue(5'b00101, 3'd6, 3'd5, 3'd2, 3, 16'h5555);

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) load(3'($urandom_range(0, 7)), 16'($urandom));
            rop = 5'($urandom_range(0, 31));
            issue(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0) ? 1 :
                  (($urandom_range(0, 2) == 0) ? 3 : 0), 16'($urandom));
        end

        // Reset during EXECUTA discards the instruction
        load(3'd1, 16'h7FFF); load(3'd2, 16'h0001);
        issue(5'b00000, 3'd3, 3'd1, 3'd2, 0, 16'h0);
        load(3'd5, 16'h1234);
        instr_op = 5'b00000; instr_rd = 3'd5; instr_ra = 3'd1; instr_rb = 3'd2;
        instr_valid = 1'b1; le_sel = 3'd5;
        wait_ready("rst_accept_timeout");
        tick();
        instr_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) mbank[i] = 16'h0000;
        mflags = 4'h0;
        chk("midrst_flags", 32'(flags), 32'd0);
        chk("midrst_rd", 32'(le_dado), 32'd0);
        chk("midrst_opA", 32'(operandoA), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_concluido", 32'(concluido), 32'd0);
            tick();
        end

        // Back-to-back with instr_valid held high
        load(3'd1, 16'h0003); load(3'd2, 16'h0004);
        bop[0] = 5'b00000; brd[0] = 3'd3; bra[0] = 3'd1; brb[0] = 3'd2;
        bop[1] = 5'b00101; brd[1] = 3'd4; bra[1] = 3'd3; brb[1] = 3'd1;
        bop[2] = 5'b10001; brd[2] = 3'd5; bra[2] = 3'd4; brb[2] = 3'd2;
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr_op = bop[k]; instr_rd = brd[k]; instr_ra = bra[k]; instr_rb = brb[k];
            u = ula(mbank[bra[k]], mbank[brb[k]], bop[k]);
            mflags = exp_flags(bop[k], u[15:0], u[17], u[16], mflags);
            mbank[brd[k]] = u[15:0];
            wait_ready("b2b_timeout");
            tick();
            tacc[k] = cyc;
        end
        instr_valid = 1'b0;
        repeat (4) tick();
        chk("b2b_spacing01", 32'(tacc[1] - tacc[0]), 32'd4);
        chk("b2b_spacing12", 32'(tacc[2] - tacc[1]), 32'd4);
        chk("b2b_flags", 32'(flags), 32'(mflags));
        for (int k = 0; k < 3; k++) begin
            le_sel = brd[k];
            #1;
            chk("b2b_result", 32'(le_dado), 32'(mbank[brd[k]]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
